// File: rtl/lf_adder_pkg.sv
// Shared types and elaboration-time helpers for the Ladner-Fischer adder pipeline.
// Pure declarations; no logic is generated here.
package lf_adder_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Prefix level vector that internal register boundary k (1..stages-1) captures.
   function automatic int boundary_level(input int k, input int levels, input int stages);
      return (k * levels) / stages;
   endfunction

   // Internal register index sitting on level vector lvl, or -1 when that vector is a plain wire.
   function automatic int stage_at(input int lvl, input int levels, input int stages);
      int s;
      s = -1;
      for (int k = 1; k < stages; k++) begin
         if (boundary_level(k, levels, stages) == lvl) s = k - 1;
      end
      return s;
   endfunction

endpackage

// File: rtl/lf_prefix_level.sv
// One Ladner-Fischer prefix level: black/grey cells merge each upper half-block with the top of its lower half.
// Latency: combinational.
// Backpressure: none, pure datapath.
module lf_prefix_level
   import lf_adder_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int LEVEL = 0
) (
   input  gp_t [WIDTH-1:0] prev,
   output gp_t [WIDTH-1:0] next
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> LEVEL) & 1) == 1) begin : g_cell
         localparam int J = ((i >> LEVEL) << LEVEL) - 1;
         assign next[i].g = prev[i].g | (prev[i].p & prev[J].g);
         // Once a group reaches bit 0 it already includes the carry-in, so its propagate is never read again.
         if (((i >> (LEVEL + 1)) << (LEVEL + 1)) == 0) begin : g_grey
            assign next[i].p = 1'b0;
         end else begin : g_black
            assign next[i].p = prev[i].p & prev[J].p;
         end
      end else begin : g_pass
         assign next[i] = prev[i];
      end
   end

endmodule

// File: rtl/lf_adder_pipe.sv
// Pipelined Ladner-Fischer adder/subtractor with carry-out and signed overflow.
// Latency: STAGES register stages from acceptance to out_valid; one beat per clock sustained.
// Backpressure: elastic per-stage valid/ready, bubbles squeezed; in_ready falls only when every stage is full and stalled.
module lf_adder_pipe
   import lf_adder_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int L = clog2(WIDTH);

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [STAGES:0]   up_vld;

   assign up_vld    = {vld, in_valid};
   assign in_ready  = adv[0];
   assign out_valid = up_vld[STAGES];

   // Ready ripples from the consumer back to the input through every stage.
   always_comb begin
      logic go;
      go  = !vld[STAGES-1] || out_ready;
      adv = '0;
      adv[STAGES-1] = go;
      for (int s = STAGES - 2; s >= 0; s--) begin
         go     = !vld[s] || go;
         adv[s] = go;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (adv[s]) vld[s] <= up_vld[s];
         end
      end
   end

   logic [WIDTH-1:0]     bx;
   logic [WIDTH-1:0]     p0;
   logic                 c0;
   gp_t  [WIDTH-1:0]     gp0;

   assign bx = b ^ {WIDTH{sub}};
   assign c0 = cin ^ sub;
   assign p0 = a ^ bx;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         gp0[i].g = a[i] & bx[i];
         gp0[i].p = p0[i];
      end
      gp0[0].g = (a[0] & bx[0]) | (p0[0] & c0);
   end

   // lv[n] is the group vector after n levels; node[n] is the same vector after an optional register.
   gp_t  [WIDTH-1:0] lv   [L+1];
   gp_t  [WIDTH-1:0] node [L+1];
   logic [WIDTH-1:0] pc   [L+1];
   logic [WIDTH-1:0] pr   [L+1];
   logic             c0c  [L+1];
   logic             c0r  [L+1];

   assign lv[0]  = gp0;
   assign pc[0]  = p0;
   assign c0c[0] = c0;

   for (genvar n = 0; n <= L; n++) begin : g_node
      localparam int S = stage_at(n, L, STAGES);
      if (S >= 0) begin : g_reg
         gp_t  [WIDTH-1:0] gp_q;
         logic [WIDTH-1:0] p_q;
         logic             c0_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               gp_q <= '0;
               p_q  <= '0;
               c0_q <= 1'b0;
            end else if (adv[S] && up_vld[S]) begin
               gp_q <= lv[n];
               p_q  <= pc[n];
               c0_q <= c0c[n];
            end
         end
         assign node[n] = gp_q;
         assign pr[n]   = p_q;
         assign c0r[n]  = c0_q;
      end else begin : g_wire
         assign node[n] = lv[n];
         assign pr[n]   = pc[n];
         assign c0r[n]  = c0c[n];
      end
      if (n < L) begin : g_lvl
         lf_prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (n)
         ) u_level (
            .prev (node[n]),
            .next (lv[n+1])
         );
         assign pc[n+1]  = pr[n];
         assign c0c[n+1] = c0r[n];
      end
   end

   logic [WIDTH-1:0] gc;
   logic [WIDTH-1:0] sum_d;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) gc[i] = node[L][i].g;
   end

   assign sum_d = pr[L] ^ {gc[WIDTH-2:0], c0r[L]};

   // Output registers only load on a real beat so the last result stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else if (adv[STAGES-1] && up_vld[STAGES-1]) begin
         sum  <= sum_d;
         cout <= gc[WIDTH-1];
         ovf  <= gc[WIDTH-1] ^ gc[WIDTH-2];
      end
   end

endmodule

// File: tb/tb_lf_adder_pipe.sv
// Directed and streamed checks of lf_adder_pipe across several widths and depths.
module tb_lf_adder_pipe;

   localparam int NI       = 5;
   localparam int IW [NI]  = '{8, 8, 8, 8, 13};
   localparam int IS [NI]  = '{1, 2, 3, 4, 3};
   localparam int NBEAT    = 100;
   localparam int MS       = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic ci, input logic su);
      logic [63:0] mask, am, bx, s;
      logic [64:0] full;
      logic        co, ov;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      am   = a & mask;
      bx   = (su ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bx} + {64'd0, ci ^ su};
      s    = full[63:0] & mask;
      co   = full[w];
      ov   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
      return {ov, co, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 64-bit, two-stage instance
   logic        m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready, m_cout, m_ovf;
   logic [63:0] m_a, m_b, m_sum;

   lf_adder_pipe #(.WIDTH(64), .STAGES(MS)) u_main (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (m_in_valid),
      .in_ready  (m_in_ready),
      .a         (m_a),
      .b         (m_b),
      .cin       (m_cin),
      .sub       (m_sub),
      .out_valid (m_out_valid),
      .out_ready (m_out_ready),
      .sum       (m_sum),
      .cout      (m_cout),
      .ovf       (m_ovf)
   );

   // Small instances sharing one stimulus bus
   logic        t_in_valid, t_out_ready, t_cin, t_sub;
   logic [63:0] t_a, t_b;
   logic        thr_en   = 1'b0;
   logic        thr_done = 1'b0;
   logic [63:0] sa [NBEAT];
   logic [63:0] sb [NBEAT];
   logic        sc [NBEAT];
   logic        ss [NBEAT];

   for (genvar k = 0; k < NI; k++) begin : g_inst
      localparam int W = IW[k];
      logic         in_ready, out_valid, cout, ovf;
      logic [W-1:0] sum;
      int rx    = 0;
      int first = -1;
      int last  = -1;

      lf_adder_pipe #(.WIDTH(W), .STAGES(IS[k])) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (t_in_valid),
         .in_ready  (in_ready),
         .a         (t_a[W-1:0]),
         .b         (t_b[W-1:0]),
         .cin       (t_cin),
         .sub       (t_sub),
         .out_valid (out_valid),
         .out_ready (t_out_ready),
         .sum       (sum),
         .cout      (cout),
         .ovf       (ovf)
      );

      always @(negedge clk) begin
         if (thr_en) begin
            if (t_in_valid) check($sformatf("thr%0d_rdy", k), 128'(in_ready), 128'(1));
            if (out_valid) begin
               if (rx < NBEAT)
                  check($sformatf("thr%0d_beat%0d", k, rx), 128'({ovf, cout, 64'(sum)}),
                        128'(ref_add(W, sa[rx], sb[rx], sc[rx], ss[rx])));
               if (first < 0) first = cyc;
               last = cyc;
               rx++;
            end
         end
      end

      initial begin
         wait (thr_done);
         check($sformatf("thr%0d_count", k), 128'(rx), 128'(NBEAT));
         check($sformatf("thr%0d_span", k), 128'(last - first + 1), 128'(NBEAT));
      end
   end

   task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic su, input logic [65:0] exp);
      int n;
      n = 0;
      m_a = a; m_b = b; m_cin = ci; m_sub = su; m_in_valid = 1'b1;
      tick();
      m_in_valid = 1'b0;
      while (!m_out_valid && n < 10) begin
         tick();
         n++;
      end
      check({tag, "_vld"}, 128'(m_out_valid), 128'(1));
      check(tag, 128'({m_ovf, m_cout, m_sum}), 128'(exp));
      tick();
   endtask

   // Targets the single-stage 8-bit instance: the result is visible right after the accepting edge.
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic su, input logic [9:0] exp);
      t_a = 64'(a); t_b = 64'(b); t_cin = ci; t_sub = su; t_in_valid = 1'b1;
      tick();
      t_in_valid = 1'b0;
      check({tag, "_vld"}, 128'(g_inst[0].out_valid), 128'(1));
      check(tag, 128'({g_inst[0].ovf, g_inst[0].cout, g_inst[0].sum}), 128'(exp));
      repeat (5) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int sent, got, occ, guard, stale, acc, cons;
      logic        held;
      logic [65:0] hv;

      rst_n = 1'b0;
      m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b1;
      t_in_valid = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0; t_sub = 1'b0; t_out_ready = 1'b1;
      for (int j = 0; j < NBEAT; j++) begin
         sa[j] = {$urandom, $urandom};
         sb[j] = {$urandom, $urandom};
         sc[j] = 1'($urandom_range(0, 1));
         ss[j] = 1'($urandom_range(0, 1));
      end

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 128'(m_out_valid), 128'(0));
      check("rst_sum",       128'(m_sum),       128'(0));
      check("rst_cout_ovf",  128'({m_cout, m_ovf}), 128'(0));
      check("rst_in_ready",  128'(m_in_ready),  128'(1));
      rst_n = 1'b1;
      tick();

      // all-ones + carry-in wraps; two cycles of latency
      m_a = {64{1'b1}}; m_b = '0; m_cin = 1'b1; m_sub = 1'b0; m_in_valid = 1'b1;
      #1;
      check("acc_in_ready", 128'(m_in_ready), 128'(1));
      tick();
      m_in_valid = 1'b0;
      check("lat_cycle1", 128'(m_out_valid), 128'(0));
      tick();
      check("lat_cycle2", 128'(m_out_valid), 128'(1));
      check("wrap", 128'({m_ovf, m_cout, m_sum}), 128'({1'b0, 1'b1, 64'h0}));
      tick();

      run64("sub_5_7",    64'd5,  64'd7, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      run64("sub_7_5",    64'd7,  64'd5, 1'b0, 1'b1, {1'b0, 1'b1, 64'h2});
      run64("sub_0_1",    64'd0,  64'd1, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      run64("sub_borrow", 64'd10, 64'd3, 1'b1, 1'b1, {1'b0, 1'b1, 64'h6});
      run64("add_ovf64",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b1, 1'b0, 64'h8000_0000_0000_0000});
      run64("add_cin",    64'h1234, 64'h0FFF, 1'b1, 1'b0, {1'b0, 1'b0, 64'h2234});

      run8("w8_add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
      run8("w8_sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
      run8("w8_wrap",     8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
      run8("w8_sub_0_1",  8'h00, 8'h01, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFF});
      run8("w8_neg_ovf",  8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00});

      // backpressure: out_ready follows 1,0,0,1,0,0,...
      sent = 0; got = 0; occ = 0; guard = 0; held = 1'b0; hv = '0;
      while (got < 10 && guard < 200) begin
         m_out_ready = (guard % 3) == 0;
         m_in_valid  = sent < 10;
         if (sent < 10) begin
            m_a = sa[sent]; m_b = sb[sent]; m_cin = sc[sent]; m_sub = ss[sent];
         end
         #1;
         check("bp_in_ready", 128'(m_in_ready), 128'(!(occ == MS && !m_out_ready)));
         if (held) begin
            check("bp_hold_vld", 128'(m_out_valid), 128'(1));
            check("bp_hold_dat", 128'({m_ovf, m_cout, m_sum}), 128'(hv));
         end
         acc  = (m_in_valid && m_in_ready) ? 1 : 0;
         cons = (m_out_valid && m_out_ready) ? 1 : 0;
         if (cons != 0) begin
            check($sformatf("bp_beat%0d", got), 128'({m_ovf, m_cout, m_sum}),
                  128'(ref_add(64, sa[got], sb[got], sc[got], ss[got])));
            got++;
         end
         held = m_out_valid && !m_out_ready;
         hv   = {m_ovf, m_cout, m_sum};
         sent += acc;
         occ  += acc - cons;
         tick();
         guard++;
      end
      check("bp_done", 128'(got), 128'(10));
      m_in_valid = 1'b0;
      m_out_ready = 1'b1;
      repeat (3) tick();

      // reset with two beats in flight
      m_out_ready = 1'b0;
      m_a = 64'd1; m_b = 64'd2; m_cin = 1'b0; m_sub = 1'b0; m_in_valid = 1'b1;
      tick();
      m_a = 64'd3;
      tick();
      m_in_valid = 1'b0;
      check("rst_pre", 128'({m_out_valid, m_sum}), 128'({1'b1, 64'd3}));
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 128'(m_out_valid), 128'(0));
      check("arst_outputs",   128'({m_ovf, m_cout, m_sum}), 128'(0));
      check("arst_in_ready",  128'(m_in_ready), 128'(1));
      tick();
      rst_n = 1'b1;
      m_out_ready = 1'b1;
      stale = 0;
      repeat (6) begin
         tick();
         if (m_out_valid) stale++;
      end
      check("rst_no_stale", 128'(stale), 128'(0));
      run64("post_rst", 64'd100, 64'd58, 1'b0, 1'b0, {1'b0, 1'b0, 64'd158});

      // full-rate stream through every small instance
      t_out_ready = 1'b1;
      thr_en = 1'b1;
      for (int j = 0; j < NBEAT; j++) begin
         t_a = sa[j]; t_b = sb[j]; t_cin = sc[j]; t_sub = ss[j]; t_in_valid = 1'b1;
         tick();
      end
      t_in_valid = 1'b0;
      repeat (10) tick();
      thr_en = 1'b0;
      thr_done = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lf_adder_pipe.md
Name: lf_adder_pipe

Overview:
Parametrised, pipelined Ladner-Fischer parallel-prefix adder/subtractor with valid/ready handshakes on both sides. It generalises the fixed 64-bit combinational adder in four ways: width is configurable, pipeline depth is configurable, subtract mode is added, and signed overflow is reported. It sits between operand-issue logic and result consumers in the datapath, and accepts one operation per cycle at full throughput.

Parameters:
- WIDTH, 64, operand/sum width. Any value ≥ 2; need not be a power of two.
- STAGES, 2, number of register stages from input acceptance to output. Range 1..L+1, where L = clog2(WIDTH) prefix levels.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; acts as borrow-in when sub=1.
- sub  in  1  1 = subtract, 0 = add.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Operand conditioning:
  - bx = b ^ {WIDTH{sub}}.
  - c0 = cin ^ sub, so sub=1, cin=0 gives a-b, and sub=1, cin=1 gives a-b-1.
- Bit signals: p = a ^ bx (propagate), g = a & bx (generate).
- Carry network:
  - Standard Ladner-Fischer, L levels.
  - c0 is folded in as bit -1 generate, i.e. G[0] = g[0] | (p[0] & c0).
  - Group terms: G[i:0] and P[i:0].
- Result:
  - sum[0] = p[0] ^ c0; sum[i] = p[i] ^ G[i-1:0].
  - cout = G[WIDTH-1:0].
  - ovf = G[WIDTH-1:0] ^ G[WIDTH-2:0] (carry-in vs carry-out of the MSB).
- Pipelining:
  - STAGES-1 internal register boundaries sit after prefix level floor(k*L/STAGES), for k = 1..STAGES-1.
  - The final register holds sum/cout/ovf.
  - Each stage carries p (needed for the sum), the current G/P vector and a valid bit.
- Latency: a beat accepted at edge N appears on out_valid after edge N+STAGES-1, i.e. STAGES cycles of register delay.
- Handshake, per stage:
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when !out_valid or out_ready.
  - in_ready = stage-0 advance condition, combinational from out_ready through the chain.
  - Bubbles are squeezed out: a full pipe with out_ready=0 holds every beat, and no data is lost or duplicated.
  - Transfer occurs only when valid && ready.
  - While out_valid=1 and out_ready=0, sum/cout/ovf are held stable.
- Simultaneous accept and emit in the same cycle is legal and sustains 1 beat/clock.
- Reset:
  - rst_n=0 clears all stage valid bits immediately: out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready is 1 during reset.
  - Reset mid-operation discards all in-flight beats; there are no partial results after release.
- Data registers: only the valid bits require reset. Data registers may reset to 0 (required on the output stage for determinism).
- Boundaries:
  - All-ones + 1 wraps to 0 with cout=1.
  - 0 - 1 gives all-ones with cout=0 (borrow).
  - WIDTH not a power of two: unused prefix positions are not instantiated.

Decomposition:
- Package lf_adder_pkg:
  - function clog2.
  - localparam-style function giving the prefix level index of boundary k.
  - gp_t pairing (g, p) for a single bit.
- Sub-module lf_prefix_level (parameters WIDTH, LEVEL): one combinational Ladner-Fischer level of black/grey cells.
- The top module instantiates L levels and interleaves the elastic stage registers.

Test Plan:
- WIDTH=64, STAGES=2; a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 → sum=0, cout=1, ovf=0; out_valid asserts 2 cycles after acceptance.
- sub=1, a=5, b=7, cin=0 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=7, b=5 → sum=2, cout=1.
- WIDTH=8, STAGES=1; a=0x7F, b=0x01, sub=0 → sum=0x80, ovf=1. Also a=0x80, b=0x01, sub=1 → sum=0x7F, ovf=1.
- Backpressure: stream 10 random beats with out_ready toggled by pattern 1,0,0,1,... → all 10 results in order, match the reference model, and are held stable while stalled. in_ready drops only when all STAGES slots are full.
- Throughput: out_ready=1 constantly, 100 back-to-back beats → 100 consecutive out_valid cycles and no bubbles. Repeat for STAGES=1..L+1.
- Reset: assert rst_n=0 with 2 beats in flight → out_valid=0 asynchronously, outputs 0. After release, no stale beat ever appears.
